conv_seq_cu: RTL and testbench

- Parametrised multi-layer convolution sequencer; successor to the single-layer conv control unit.
- Runs a programmable number of layers. Each layer has a memory-read phase and a PE phase, and the memory-read phase can be skipped per layer.
- Handshakes with the memory loader and PE array through level start / done pairs.
- Adds a per-phase watchdog and a sticky error state. Sits at the top of the conv datapath, driven by the host start strobe.

---
 rtl/conv_seq_cu.sv | 123 ++++++++++++
 tb/tb_conv_seq_cu.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_cu.sv
`default_nettype none
// ============================================================================
// Module   : conv_seq_cu
// Brief    : Multi-layer convolution sequencer (MEM/PE phases, watchdog, ERR)
// Revision : 1.0
// ============================================================================
module conv_seq_cu #(
    parameter int MAX_LAYERS  = 4,
    parameter int LW          = $clog2(MAX_LAYERS + 1),
    parameter int TIMEOUT_CYC = 1024,
    parameter int TW          = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LW-1:0]         num_layers,
    input  logic [MAX_LAYERS-1:0] skip_mem_mask,
    input  logic                  done_mem,
    input  logic                  done_pe,
    output logic                  start_mem,
    output logic                  start_pe,
    output logic [LW-1:0]         layer_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout
);

    // A zero-cycle timeout gives TW=0; keep a 1-bit counter so widths stay legal.
    localparam int                     c_cnt_w      = (TW < 1) ? 1 : TW;
    localparam logic [c_cnt_w-1:0]     c_wd_limit   = c_cnt_w'(TIMEOUT_CYC - 1);
    localparam bit                     c_wd_en      = (TIMEOUT_CYC > 0);
    localparam logic [LW-1:0]          c_max_layers = LW'(MAX_LAYERS);
    localparam logic [MAX_LAYERS-1:0]  c_mask_one   = MAX_LAYERS'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_SEL  = 3'd2,
        ST_MEM  = 3'd3,
        ST_PE   = 3'd4,
        ST_NEXT = 3'd5,
        ST_DONE = 3'd6,
        ST_ERR  = 3'd7
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [LW-1:0]           r_count;
    logic [MAX_LAYERS-1:0]   r_mask;
    logic [LW-1:0]           r_layer_idx;
    logic [c_cnt_w-1:0]      r_wd_cnt;

    logic [LW-1:0]           w_count_clamped;
    logic                    w_skip;
    logic                    w_last;
    logic                    w_wd_hit;

    assign w_count_clamped = (num_layers > c_max_layers) ? c_max_layers : num_layers;
    assign w_skip          = |(r_mask & (c_mask_one << r_layer_idx));
    assign w_last          = (r_layer_idx == (r_count - LW'(1)));
    assign w_wd_hit        = c_wd_en && (r_wd_cnt == c_wd_limit);

    // Phase done is checked before the watchdog so a same-cycle done wins.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_ARM;
            ST_ARM:  if (!start) w_state_next = (r_count == '0) ? ST_DONE : ST_SEL;
            ST_SEL:  w_state_next = w_skip ? ST_PE : ST_MEM;
            ST_MEM: begin
                if (done_mem)      w_state_next = ST_PE;
                else if (w_wd_hit) w_state_next = ST_ERR;
            end
            ST_PE: begin
                if (done_pe)       w_state_next = ST_NEXT;
                else if (w_wd_hit) w_state_next = ST_ERR;
            end
            ST_NEXT: w_state_next = w_last ? ST_DONE : ST_SEL;
            ST_DONE: w_state_next = ST_IDLE;
            ST_ERR:  if (start) w_state_next = ST_ARM;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_mask      <= '0;
            r_layer_idx <= '0;
            r_wd_cnt    <= '0;
        end else begin
            r_state <= w_state_next;

            if ((w_state_next == ST_ARM) && (r_state != ST_ARM)) begin
                r_count <= w_count_clamped;
                r_mask  <= skip_mem_mask;
            end

            if ((r_state == ST_ARM) && (w_state_next == ST_SEL)) begin
                r_layer_idx <= '0;
            end else if ((r_state == ST_NEXT) && (w_state_next == ST_SEL)) begin
                r_layer_idx <= r_layer_idx + LW'(1);
            end

            // Any state change restarts the watchdog, so each phase starts at 0.
            if (w_state_next != r_state) begin
                r_wd_cnt <= '0;
            end else if (c_wd_en && ((r_state == ST_MEM) || (r_state == ST_PE))) begin
                r_wd_cnt <= r_wd_cnt + c_cnt_w'(1);
            end
        end
    end

    assign start_mem = (r_state == ST_MEM);
    assign start_pe  = (r_state == ST_PE);
    assign layer_idx = r_layer_idx;
    assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERR);
    assign done      = (r_state == ST_DONE);
    assign timeout   = (r_state == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_cu.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_seq_cu
// Brief    : Self-checking bench for conv_seq_cu with a trace-building model
// Revision : 1.0
// ============================================================================
module tb_conv_seq_cu;

    localparam int MAXL = 4;
    localparam int LW   = 3;
    localparam int TO   = 8;

    typedef logic [7:0] vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [LW-1:0]   num_layers = '0;
    logic [MAXL-1:0] skip_mem_mask = '0;
    logic            done_mem = 1'b0;
    logic            done_pe = 1'b0;
    logic            start_mem, start_pe, busy, done, timeout;
    logic [LW-1:0]   layer_idx;

    conv_seq_cu #(
        .MAX_LAYERS (MAXL),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_layers   (num_layers),
        .skip_mem_mask(skip_mem_mask),
        .done_mem     (done_mem),
        .done_pe      (done_pe),
        .start_mem    (start_mem),
        .start_pe     (start_pe),
        .layer_idx    (layer_idx),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t exp_q[$];
    int   m_idx = 0;
    bit   m_err = 1'b0;
    int   dm_cfg = 0, dp_cfg = 0, hang_cfg = -1;
    bit   noise_on = 1'b0;
    int   mem_cnt = 0, pe_cnt = 0;
    int   sm_rise = 0, sp_rise = 0, done_cnt = 0;
    logic prev_sm = 1'b0, prev_sp = 1'b0;
    int   last_len = 0;

    function automatic vec_t mk(input bit sm, input bit sp, input bit b, input bit d,
                                input bit t, input int idx);
        return {sm, sp, b, d, t, idx[2:0]};
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // One clock: compare outputs to the model, update monitors, drive responder.
    task automatic cycle();
        vec_t act, exp;
        @(negedge clk);
        act = {start_mem, start_pe, busy, done, timeout, layer_idx};
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        else exp = m_err ? mk(0, 0, 0, 0, 1, m_idx) : mk(0, 0, 0, 0, 0, m_idx);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL cycle_outputs @%0t: got sm,sp,busy,done,to,idx=%b, required %b",
                      $time, act, exp);
        if (start_mem && !prev_sm) sm_rise++;
        if (start_pe && !prev_sp) sp_rise++;
        if (done) done_cnt++;
        prev_sm = start_mem;
        prev_sp = start_pe;
        if (start_mem) begin
            mem_cnt++;
            done_mem = (mem_cnt == dm_cfg);
        end else begin
            mem_cnt = 0;
            done_mem = 1'b0;
        end
        if (start_pe) begin
            pe_cnt++;
            done_pe = (int'(layer_idx) != hang_cfg) && (pe_cnt == dp_cfg);
        end else begin
            pe_cnt = 0;
            done_pe = 1'b0;
        end
        if (noise_on) begin
            if (start_mem) done_pe = 1'b1;
            if (start_pe) done_mem = 1'b1;
            start = start_mem | start_pe;
        end
    endtask

    // A phase lasts d cycles if d is within the watchdog limit, else TO cycles then ERR.
    task automatic push_phase(input bit mem, input int d, input int l, inout bit dead);
        int len;
        len = (d >= 1 && d <= TO) ? d : TO;
        repeat (len) exp_q.push_back(mk(mem, !mem, 1, 0, 0, l));
        if (!(d >= 1 && d <= TO)) begin
            dead  = 1'b1;
            m_err = 1'b1;
            m_idx = l;
        end
    endtask

    task automatic run(input int n, input int mask, input int dm, input int dp,
                       input int hang, input int h, input bit noise);
        int cnt, prev, guard;
        bit dead;
        cycle();
        sm_rise = 0; sp_rise = 0; done_cnt = 0;
        dm_cfg = dm; dp_cfg = dp; hang_cfg = hang;
        start = 1'b1;
        num_layers = n[LW-1:0];
        skip_mem_mask = mask[MAXL-1:0];
        prev  = m_idx;
        m_err = 1'b0;
        dead  = 1'b0;
        cnt   = (n > MAXL) ? MAXL : n;
        repeat (h) exp_q.push_back(mk(0, 0, 1, 0, 0, prev));
        if (cnt == 0) begin
            exp_q.push_back(mk(0, 0, 0, 1, 0, prev));
        end else begin
            for (int l = 0; l < cnt && !dead; l++) begin
                exp_q.push_back(mk(0, 0, 1, 0, 0, l));
                if (((mask >> l) & 1) == 0) push_phase(1'b1, dm, l, dead);
                if (!dead) push_phase(1'b0, (l == hang) ? 0 : dp, l, dead);
                if (!dead) exp_q.push_back(mk(0, 0, 1, 0, 0, l));
            end
            if (!dead) begin
                exp_q.push_back(mk(0, 0, 0, 1, 0, cnt - 1));
                m_idx = cnt - 1;
            end
        end
        last_len = exp_q.size();
        repeat (h) cycle();
        start = 1'b0;
        noise_on = noise;
        guard = 0;
        while (exp_q.size() > 0 && guard < 2000) begin
            cycle();
            guard++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_bound", exp_q.size(), 0);
            exp_q.delete();
        end
        noise_on = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (10) cycle();
        chk("idle_busy", busy, 0);
        chk("idle_layer_idx", layer_idx, 0);

        run(3, 0, 4, 4, -1, 2, 1'b0);
        chk("l3_mem_phases", sm_rise, 3);
        chk("l3_pe_phases", sp_rise, 3);
        chk("l3_done_pulses", done_cnt, 1);

        run(2, 2, 4, 4, -1, 1, 1'b0);
        chk("skip_mem_phases", sm_rise, 1);
        chk("skip_pe_phases", sp_rise, 2);
        chk("skip_done_pulses", done_cnt, 1);

        run(1, 0, 1, 1, -1, 1, 1'b0);
        chk("min_latency_trace_len", last_len, 6);
        chk("min_latency_done", done_cnt, 1);

        run(0, 0, 1, 1, -1, 1, 1'b0);
        chk("zero_trace_len", last_len, 2);
        chk("zero_phases", sm_rise + sp_rise, 0);
        chk("zero_done", done_cnt, 1);

        run(7, 0, 1, 1, -1, 1, 1'b0);
        chk("clamp_pe_phases", sp_rise, 4);
        chk("clamp_last_idx", layer_idx, 3);

        run(2, 0, 3, 3, -1, 1, 1'b1);
        chk("noise_done", done_cnt, 1);

        run(3, 0, 2, 2, 1, 1, 1'b0);
        chk("wd_trace_len", last_len, 18);
        repeat (6) cycle();
        chk("err_timeout", timeout, 1);
        chk("err_busy", busy, 0);
        chk("err_idx", layer_idx, 1);
        chk("err_no_done", done_cnt, 0);

        run(1, 0, 2, 2, -1, 1, 1'b0);
        chk("restart_done", done_cnt, 1);
        chk("restart_timeout", timeout, 0);

        run(1, 0, 8, 2, -1, 1, 1'b0);
        chk("collide_mem_done", done_cnt, 1);
        run(1, 1, 0, 8, -1, 1, 1'b0);
        chk("collide_pe_done", done_cnt, 1);

        // Abort mid-PE with an asynchronous reset pulse.
        cycle();
        sm_rise = 0; sp_rise = 0; done_cnt = 0;
        dm_cfg = 2; dp_cfg = 4; hang_cfg = -1;
        start = 1'b1; num_layers = 3'd2; skip_mem_mask = '0;
        exp_q.push_back(mk(0, 0, 1, 0, 0, m_idx));
        exp_q.push_back(mk(0, 0, 1, 0, 0, 0));
        repeat (2) exp_q.push_back(mk(1, 0, 1, 0, 0, 0));
        repeat (2) exp_q.push_back(mk(0, 1, 1, 0, 0, 0));
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        chk("abort_in_pe", start_pe, 1);
        #1 rst_n = 1'b0;
        #1 chk("abort_outputs", int'({start_mem, start_pe, busy, done, timeout, layer_idx}), 0);
        m_idx = 0; m_err = 1'b0; exp_q.delete();
        done_mem = 1'b0; done_pe = 1'b0; mem_cnt = 0; pe_cnt = 0;
        #1 rst_n = 1'b1;
        repeat (6) cycle();
        chk("abort_no_done", done_cnt, 0);

        run(1, 0, 1, 1, -1, 1, 1'b0);
        chk("post_abort_done", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
